// File: rtl/rggen_irq_status_sequencer.sv
// rggen_irq_status_sequencer: round-robin interrupt sequencer for a bank of set-mode w01c status fields
//   i_event/o_set         : event pulses registered into set strobes for the status fields
//   i_enable/i_status     : field enables and current field values
//   o_irq_valid/o_irq_id/i_irq_ack : one-at-a-time interrupt presentation handshake
//   o_in_service/o_busy   : acknowledged sources awaiting software clear, activity flag
module rggen_irq_status_sequencer #(
  parameter int N   = 8,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   i_event,
  input  logic [N-1:0]   i_enable,
  input  logic [N-1:0]   i_status,
  output logic [N-1:0]   o_set,
  output logic           o_irq_valid,
  output logic [IDW-1:0] o_irq_id,
  input  logic           i_irq_ack,
  output logic [N-1:0]   o_in_service,
  output logic           o_busy
);
  typedef enum logic {IDLE, PRESENT} state_t;
  state_t         state, state_next;
  logic [IDW-1:0] rr_ptr, rr_next, sel, id_next;
  logic [N-1:0]   candidate, ack_bit;
  logic           found;
  assign candidate = i_status & i_enable & ~o_in_service;
  assign found     = |candidate;
  // Downward scans leave the lowest hit; the second scan overrides with the
  // lowest hit at or above rr_ptr, giving wrap-around round-robin order.
  always_comb begin
    sel = '0;
    for (int i = N - 1; i >= 0; i--) if (candidate[i]) sel = IDW'(i);
    for (int i = N - 1; i >= 0; i--) if (candidate[i] && IDW'(i) >= rr_ptr) sel = IDW'(i);
  end
  always_comb begin
    state_next = state;
    id_next    = o_irq_id;
    rr_next    = rr_ptr;
    ack_bit    = '0;
    if (state == IDLE) begin
      state_next = found ? PRESENT : IDLE;
      id_next    = found ? sel : o_irq_id;
    end else if (i_irq_ack) begin
      ack_bit[o_irq_id] = 1'b1;
      rr_next    = (o_irq_id == IDW'(N - 1)) ? '0 : o_irq_id + 1'b1;
      state_next = IDLE;
    end else if (!candidate[o_irq_id]) begin
      state_next = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      o_set        <= '0;
      o_irq_id     <= '0;
      rr_ptr       <= '0;
      o_in_service <= '0;
    end else begin
      state        <= state_next;
      o_set        <= i_event;
      o_irq_id     <= id_next;
      rr_ptr       <= rr_next;
      // a cleared status bit wins over an ack landing in the same cycle
      o_in_service <= (o_in_service | ack_bit) & i_status;
    end
  end
  assign o_irq_valid = (state == PRESENT);
  assign o_busy      = (state != IDLE) | (|o_in_service);
endmodule

// File: tb/tb_rggen_irq_status_sequencer.sv
// tb_rggen_irq_status_sequencer: vector table, latency sequence and randomized model check
module tb_rggen_irq_status_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] i_event = '0, i_enable = '0, i_status = '0;
  logic [3:0] o_set, o_in_service;
  logic       o_irq_valid, i_irq_ack = 1'b0, o_busy;
  logic [1:0] o_irq_id;
  int passed = 0, total = 0;
  rggen_irq_status_sequencer #(.N(4)) dut (
    .clk(clk), .rst(rst), .i_event(i_event), .i_enable(i_enable), .i_status(i_status),
    .o_set(o_set), .o_irq_valid(o_irq_valid), .o_irq_id(o_irq_id), .i_irq_ack(i_irq_ack),
    .o_in_service(o_in_service), .o_busy(o_busy)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic rst; logic [3:0] ev, en, st; logic ack;
    logic [3:0] set; logic vld; logic [1:0] id; logic [3:0] insv; logic busy;
  } vec_t;
  vec_t vecs[$];
  logic [3:0] m_set, m_insv;
  logic       m_vld;
  int         m_id, m_ptr;
  function automatic logic [11:0] outs();
    return {o_set, o_irq_valid, o_irq_id, o_in_service, o_busy};
  endfunction
  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic v(input logic r, input logic [3:0] ev, en, st, input logic ak,
                   input logic [3:0] set, input logic vld, input logic [1:0] id,
                   input logic [3:0] insv, input logic busy);
    vecs.push_back('{r, ev, en, st, ak, set, vld, id, insv, busy});
  endtask
  task automatic drive(input logic r, input logic [3:0] ev, en, st, input logic ak);
    rst = r; i_event = ev; i_enable = en; i_status = st; i_irq_ack = ak;
  endtask
  // Reference: pending set = enabled & raised & not in service; the next
  // presentation is the pending source nearest at or after the pointer, modulo 4.
  task automatic model_step(input logic r, input logic [3:0] ev, en, st, input logic ak);
    logic [3:0] pend, insv_n;
    if (r) begin
      m_set = '0; m_vld = 1'b0; m_id = 0; m_ptr = 0; m_insv = '0;
      return;
    end
    pend   = st & en & ~m_insv;
    insv_n = m_insv;
    m_set  = ev;
    if (!m_vld) begin
      for (int off = 0; off < 4; off++)
        if (pend[(m_ptr + off) % 4]) begin
          m_vld = 1'b1; m_id = (m_ptr + off) % 4;
          break;
        end
    end else if (ak) begin
      insv_n[m_id] = 1'b1; m_ptr = (m_id + 1) % 4; m_vld = 1'b0;
    end else if (!pend[m_id]) begin
      m_vld = 1'b0;
    end
    m_insv = insv_n & st;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [3:0] field;
    int first, fid;
    logic [3:0] set1;
    // rst ev en st ack | set vld id insv busy
    v(1,4'b0000,4'b1111,4'b0000,0, 4'b0000,0,0,4'b0000,0);
    v(0,4'b0100,4'b1111,4'b0000,0, 4'b0100,0,0,4'b0000,0);
    v(0,4'b0000,4'b1111,4'b0000,0, 4'b0000,0,0,4'b0000,0);
    v(0,4'b0000,4'b1111,4'b0100,0, 4'b0000,1,2,4'b0000,1);
    v(0,4'b0000,4'b1111,4'b0100,1, 4'b0000,0,2,4'b0100,1);
    v(0,4'b0000,4'b1111,4'b0100,0, 4'b0000,0,2,4'b0100,1);
    v(0,4'b0000,4'b1111,4'b0000,0, 4'b0000,0,2,4'b0000,0);
    v(1,4'b0000,4'b1111,4'b1011,0, 4'b0000,0,0,4'b0000,0);
    v(0,4'b0000,4'b1111,4'b1011,1, 4'b0000,1,0,4'b0000,1);
    v(0,4'b0000,4'b1111,4'b1011,1, 4'b0000,0,0,4'b0001,1);
    v(0,4'b0000,4'b1111,4'b1011,0, 4'b0000,1,1,4'b0001,1);
    v(0,4'b0000,4'b1111,4'b1011,1, 4'b0000,0,1,4'b0011,1);
    v(0,4'b0000,4'b1111,4'b1011,0, 4'b0000,1,3,4'b0011,1);
    v(0,4'b0000,4'b1111,4'b1011,1, 4'b0000,0,3,4'b1011,1);
    v(0,4'b0000,4'b1111,4'b1010,0, 4'b0000,0,3,4'b1010,1);
    v(0,4'b0000,4'b1111,4'b1011,0, 4'b0000,1,0,4'b1010,1);
    v(0,4'b0000,4'b1111,4'b1011,1, 4'b0000,0,0,4'b1011,1);
    v(0,4'b0000,4'b1111,4'b0000,0, 4'b0000,0,0,4'b0000,0);
    v(0,4'b0000,4'b1111,4'b0010,0, 4'b0000,1,1,4'b0000,1);
    v(0,4'b0000,4'b1111,4'b0010,0, 4'b0000,1,1,4'b0000,1);
    v(0,4'b0000,4'b1111,4'b0000,0, 4'b0000,0,1,4'b0000,0);
    v(0,4'b0000,4'b1111,4'b0011,0, 4'b0000,1,1,4'b0000,1);
    v(0,4'b0000,4'b1111,4'b0011,1, 4'b0000,0,1,4'b0010,1);
    v(0,4'b0000,4'b1111,4'b0000,0, 4'b0000,0,1,4'b0000,0);
    v(0,4'b1000,4'b0000,4'b0000,0, 4'b1000,0,1,4'b0000,0);
    v(0,4'b0000,4'b0000,4'b0000,1, 4'b0000,0,1,4'b0000,0);
    v(0,4'b0000,4'b0000,4'b1000,0, 4'b0000,0,1,4'b0000,0);
    v(0,4'b0000,4'b1000,4'b1000,0, 4'b0000,1,3,4'b0000,1);
    v(0,4'b0000,4'b1000,4'b0000,1, 4'b0000,0,3,4'b0000,0);
    v(0,4'b0000,4'b1111,4'b1010,0, 4'b0000,1,1,4'b0000,1);
    v(0,4'b0000,4'b1111,4'b1010,1, 4'b0000,0,1,4'b0010,1);
    v(0,4'b0000,4'b1111,4'b1010,0, 4'b0000,1,3,4'b0010,1);
    v(1,4'b0000,4'b1111,4'b1010,0, 4'b0000,0,0,4'b0000,0);
    v(0,4'b0000,4'b1111,4'b0010,0, 4'b0000,1,1,4'b0000,1);
    foreach (vecs[r]) begin
      @(negedge clk);
      if (r > 0)
        check($sformatf("vec[%0d]", r - 1), outs(),
              {vecs[r-1].set, vecs[r-1].vld, vecs[r-1].id, vecs[r-1].insv, vecs[r-1].busy});
      drive(vecs[r].rst, vecs[r].ev, vecs[r].en, vecs[r].st, vecs[r].ack);
    end
    @(negedge clk);
    check($sformatf("vec[%0d]", vecs.size() - 1), outs(),
          {vecs[$].set, vecs[$].vld, vecs[$].id, vecs[$].insv, vecs[$].busy});
    // end-to-end latency through a modelled w01c status field
    drive(1, '0, 4'b1111, '0, 0);
    @(negedge clk);
    drive(0, 4'b0100, 4'b1111, '0, 0);
    field = '0; first = -1; fid = 0; set1 = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      i_event = '0;
      if (c == 1) set1 = o_set;
      if (o_irq_valid && first < 0) begin first = c; fid = int'(o_irq_id); end
      i_status = field;
      field = field | o_set;
    end
    check("latency_set", {8'd0, set1}, 12'h004);
    check("latency_valid_cycle_id", 12'(first * 16 + fid), 12'(3 * 16 + 2));
    // randomized run against the reference model
    for (int i = 0; i < 600; i++) begin
      logic r, ak;
      logic [3:0] ev, en, st;
      @(negedge clk);
      if (i > 0)
        check($sformatf("rand[%0d]", i), outs(),
              {m_set, m_vld, 2'(m_id), m_insv, m_vld | (|m_insv)});
      r  = (i == 0) || ($urandom_range(0, 79) == 0);
      ev = 4'($urandom) & 4'($urandom);
      en = ($urandom_range(0, 15) == 0) ? 4'($urandom) : i_enable;
      st = i_status ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      ak = $urandom_range(0, 2) == 0;
      drive(r, ev, en, st, ak);
      model_step(r, ev, en, st, ak);
    end
    @(negedge clk);
    check("rand_last", outs(), {m_set, m_vld, 2'(m_id), m_insv, m_vld | (|m_insv)});
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
